// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Op encodings match the two-bit operation field driven by the pipeline.
package hilo_pkg;

    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative unsigned datapath: one shift-add (multiply) or restoring-subtract
// (divide) step per i_step. Result layout is {hi, lo} for both operations.
module hilo_iter_core
    import hilo_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_is_div,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_last,
    output logic [63:0] o_result
);

    logic [63:0]      r_acc;
    logic [31:0]      r_opb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;

    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;

    // Multiply: the 33-bit sum carries into bit 63 after the right shift.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
        w_mul_next = {w_mul_sum, r_acc[31:1]};
    end

    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient bits in.
    always_comb begin
        w_div_shift = {r_acc[63:32], r_acc[31]};
        w_div_trial = w_div_shift - {1'b0, r_opb};
        if (w_div_trial[32]) begin
            w_div_next = {w_div_shift[31:0], r_acc[30:0], 1'b0};
        end else begin
            w_div_next = {w_div_trial[31:0], r_acc[30:0], 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc  <= 64'd0;
            r_opb  <= 32'd0;
            r_cnt  <= '0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_acc  <= {32'd0, i_a};
            r_opb  <= i_b;
            r_cnt  <= CNT_W'(ITER - 1);
            r_last <= 1'b0;
        end else if (i_step) begin
            r_acc  <= i_is_div ? w_div_next : w_mul_next;
            r_last <= (r_cnt == '0);
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_last   = r_last;
    assign o_result = r_acc;

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS HI/LO register pair with an iterative MULT/MULTU/DIV/DIVU engine.
// Signed operations run on magnitudes; signs are restored in the FIX state.
module hilo_muldiv
    import hilo_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_by_zero,
    input  logic        i_write_hi,
    input  logic        i_write_lo,
    input  logic [31:0] i_write_data,
    input  logic        i_read_sel,
    output logic [31:0] o_read_data,
    output logic [31:0] o_high,
    output logic [31:0] o_low
);

    state_e r_state;
    state_e w_state_next;

    logic        r_is_div;
    logic        r_neg_main;
    logic        r_neg_rem;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dbz;

    logic        w_accept;
    logic        w_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_last;
    logic        w_step;
    logic [63:0] w_res;
    logic [63:0] w_prod;
    logic [31:0] w_fix_hi;
    logic [31:0] w_fix_lo;

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_signed = (op_e'(i_op) == OP_MULT) || (op_e'(i_op) == OP_DIV);
    assign w_neg_a  = w_signed && i_a[31];
    assign w_neg_b  = w_signed && i_b[31];
    assign w_mag_a  = w_neg_a ? neg32(i_a) : i_a;
    assign w_mag_b  = w_neg_b ? neg32(i_b) : i_b;
    assign w_step   = (r_state == RUN) && !w_last;

    hilo_iter_core u_core (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_is_div (r_is_div),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_last   (w_last),
        .o_result (w_res)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Sign correction; a zero divisor forces an all-ones quotient even when
    // the sign rule would flip it, while the remainder already equals A.
    always_comb begin
        w_prod   = r_neg_main ? neg64(w_res) : w_res;
        w_fix_hi = w_prod[63:32];
        w_fix_lo = w_prod[31:0];
        if (r_is_div) begin
            w_fix_hi = r_neg_rem ? neg32(w_res[63:32]) : w_res[63:32];
            if (r_div_zero) begin
                w_fix_lo = 32'hFFFF_FFFF;
            end else begin
                w_fix_lo = r_neg_main ? neg32(w_res[31:0]) : w_res[31:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_is_div   <= i_op[1];
            r_neg_main <= w_neg_a ^ w_neg_b;
            r_neg_rem  <= w_neg_a;
            r_div_zero <= (i_b == 32'd0);
        end
    end

    // Pipeline writes land only while idle; FIX is busy, so the result wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            r_dbz  <= (r_state == FIX) && r_is_div && r_div_zero;
            if (r_state == FIX) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end else if (r_state == IDLE) begin
                if (i_write_hi) r_hi <= i_write_data;
                if (i_write_lo) r_lo <= i_write_data;
            end
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_high        = r_hi;
    assign o_low         = r_lo;
    assign o_read_data   = i_read_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: arithmetic results, latency, MT/MF ports,
// busy-time filtering and asynchronous reset abort.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        dbz;
    logic        whi;
    logic        wlo;
    logic [31:0] wdata;
    logic        rsel;
    logic [31:0] rdata;
    logic [31:0] high;
    logic [31:0] low;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;

    hilo_muldiv dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_op          (op),
        .i_a           (a),
        .i_b           (b),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz),
        .i_write_hi    (whi),
        .i_write_lo    (wlo),
        .i_write_data  (wdata),
        .i_read_sel    (rsel),
        .o_read_data   (rdata),
        .o_high        (high),
        .o_low         (low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Holds Start for one edge; called at #1 after an edge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 50; n++) begin
            if (done) break;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_lat"}, 64'(cyc - accept_cyc), 64'd34);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
        start_op(o, x, y);
        check_eq({tag, "_busy0"}, 64'(busy), 64'd1);
        wait_done(tag);
        check_eq({tag, "_hi"}, 64'(high), 64'(ehi));
        check_eq({tag, "_lo"}, 64'(low), 64'(elo));
        check_eq({tag, "_dbz"}, 64'(dbz), 64'(edbz));
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        whi   = 1'b0;
        wlo   = 1'b0;
        wdata = 32'd0;
        rsel  = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check_eq("rst_hi", 64'(high), 64'd0);
        check_eq("rst_lo", 64'(low), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dbz", 64'(dbz), 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("multu_carry", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'd0, 1'b0);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0);

        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        check_eq("divu_zero_dbz_pulse", 64'(dbz), 64'd0);
        check_eq("divu_zero_done_pulse", 64'(done), 64'd0);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // Write with an accepted Start lands, then the result overwrites it.
        wlo   = 1'b1;
        wdata = 32'h1111_2222;
        start_op(2'b01, 32'd6, 32'd7);
        wlo = 1'b0;
        check_eq("mt_with_start", 64'(low), 64'h1111_2222);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd9;
        b     = 32'd9;
        whi   = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        whi   = 1'b0;
        check_eq("busy_write_dropped", 64'(high), 64'h0000_0000);
        wait_done("ignore");
        check_eq("ignore_hi", 64'(high), 64'd0);
        check_eq("ignore_lo", 64'(low), 64'd42);

        // Back-to-back: Start in the Done cycle.
        run_op("b2b", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        // Idle MTHI then MTLO.
        whi   = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        whi   = 1'b0;
        wlo   = 1'b1;
        wdata = 32'h5A5A_5A5A;
        rsel  = 1'b1;
        #1;
        check_eq("mthi_read", 64'(rdata), 64'hA5A5_A5A5);
        rsel = 1'b0;
        #1;
        check_eq("mtlo_before", 64'(rdata), 64'd12);
        @(posedge clk);
        #1;
        wlo = 1'b0;
        check_eq("mtlo_read", 64'(rdata), 64'h5A5A_5A5A);
        rsel = 1'b1;
        #1;
        check_eq("mthi_hold", 64'(rdata), 64'hA5A5_A5A5);

        // Asynchronous abort partway through a divide.
        start_op(2'b11, 32'hFFFF_0000, 32'd3);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_hi", 64'(high), 64'd0);
        check_eq("abort_lo", 64'(low), 64'd0);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", 64'(done_cnt), 64'd0);
        check_eq("abort_idle", 64'(busy), 64'd0);
        run_op("post_reset", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
